phase_measure_ctrl: RTL and testbench

//  Sequences one start/stop phase detector for a measurement burst.
//  - On a start command, holds the detector in reset for one cycle, then releases it.
//  - Collects a programmed number of phase_tag samples, or stops on a no-sample timeout.
//  - Reports sum/min/max/count of the phase field through a valid/ready result port.
//  - Sits between the detector (clk_sample domain) and the host/control logic.

---
 rtl/phase_measure_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_phase_measure_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : phase_measure_ctrl
// Description : Burst sequencer for one start/stop phase detector.
//               A start command holds the detector in reset for one cycle,
//               then collects a programmed number of phase samples (or stops
//               on a no-sample gap timeout) and reports sum/min/max/count of
//               the phase field through a valid/ready result port.
// Ports       : clk_sample, rst          - sample clock, sync active-high reset
//               start, num_samples,
//               timeout_cycles           - burst command and configuration
//               busy, pd_rst             - status / detector reset
//               phase_tag, phase_tag_valid - detector tag stream
//               result_valid, result_ready,
//               result_sum/min/max/count/timeout - burst result
// Revision    : 1.0 - initial release
// ============================================================================
module phase_measure_ctrl #(
    parameter int PHASE_COUNT_W = 12,
    parameter int CLK0_COUNT_W  = 4,
    parameter int NSAMP_W       = 8,
    parameter int TIMEOUT_W     = 20,
    parameter int ACC_W         = PHASE_COUNT_W + NSAMP_W
) (
    input  logic                                  clk_sample,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [NSAMP_W-1:0]                    num_samples,
    input  logic [TIMEOUT_W-1:0]                  timeout_cycles,
    output logic                                  busy,
    output logic                                  pd_rst,
    input  logic [PHASE_COUNT_W+CLK0_COUNT_W-1:0] phase_tag,
    input  logic                                  phase_tag_valid,
    output logic                                  result_valid,
    input  logic                                  result_ready,
    output logic [ACC_W-1:0]                      result_sum,
    output logic [PHASE_COUNT_W-1:0]              result_min,
    output logic [PHASE_COUNT_W-1:0]              result_max,
    output logic [NSAMP_W-1:0]                    result_count,
    output logic                                  result_timeout
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARM     = 2'd1;
    localparam logic [1:0] c_ST_COLLECT = 2'd2;
    localparam logic [1:0] c_ST_REPORT  = 2'd3;

    localparam logic [TIMEOUT_W-1:0] c_GAP_MAX = '1;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;

    logic [NSAMP_W-1:0]       r_nsamp;
    logic [TIMEOUT_W-1:0]     r_timeout;
    logic [NSAMP_W-1:0]       r_count;
    logic [TIMEOUT_W-1:0]     r_gap;
    logic [ACC_W-1:0]         r_sum;
    logic [PHASE_COUNT_W-1:0] r_min;
    logic [PHASE_COUNT_W-1:0] r_max;

    logic [PHASE_COUNT_W-1:0] w_phase;
    logic [NSAMP_W-1:0]       w_count_inc;
    logic [ACC_W-1:0]         w_sum_nxt;
    logic [PHASE_COUNT_W-1:0] w_min_nxt;
    logic [PHASE_COUNT_W-1:0] w_max_nxt;
    logic                     w_timeout_hit;
    logic                     w_unused_tag_hi;

    // Only the phase field matters; the clk_0 count in the upper bits is
    // carried by the detector for other consumers.
    assign w_phase         = phase_tag[PHASE_COUNT_W-1:0];
    assign w_unused_tag_hi = ^phase_tag[PHASE_COUNT_W+CLK0_COUNT_W-1:PHASE_COUNT_W];

    // Accumulator values including the sample presented this cycle.
    assign w_count_inc = r_count + NSAMP_W'(1);
    assign w_sum_nxt   = r_sum + ACC_W'(w_phase);
    assign w_min_nxt   = (w_phase < r_min) ? w_phase : r_min;
    assign w_max_nxt   = (w_phase > r_max) ? w_phase : r_max;

    // r_gap counts idle cycles already elapsed, so the burst ends on the
    // timeout_cycles-th consecutive cycle without a sample. A sample arriving
    // in that same cycle wins over the timeout.
    assign w_timeout_hit = (r_timeout != '0) &&
                           (r_gap == (r_timeout - TIMEOUT_W'(1))) &&
                           !phase_tag_valid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_samples == '0) ? c_ST_REPORT : c_ST_ARM;
                end
            end
            c_ST_ARM: begin
                w_state_nxt = c_ST_COLLECT;
            end
            c_ST_COLLECT: begin
                if (phase_tag_valid) begin
                    if (w_count_inc == r_nsamp) begin
                        w_state_nxt = c_ST_REPORT;
                    end
                end else if (w_timeout_hit) begin
                    w_state_nxt = c_ST_REPORT;
                end
            end
            c_ST_REPORT: begin
                if (result_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered status outputs (decoded from the
    // next state so they line up with the state they describe).
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sample) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            busy         <= 1'b0;
            pd_rst       <= 1'b1;
            result_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            busy         <= (w_state_nxt != c_ST_IDLE);
            pd_rst       <= (w_state_nxt != c_ST_COLLECT);
            result_valid <= (w_state_nxt == c_ST_REPORT);
        end
    end

    // ------------------------------------------------------------------
    // Configuration, accumulators and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sample) begin
        if (rst) begin
            r_nsamp        <= '0;
            r_timeout      <= '0;
            r_count        <= '0;
            r_gap          <= '0;
            r_sum          <= '0;
            r_min          <= '0;
            r_max          <= '0;
            result_sum     <= '0;
            result_min     <= '0;
            result_max     <= '0;
            result_count   <= '0;
            result_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_nsamp   <= num_samples;
                        r_timeout <= timeout_cycles;
                        // An empty burst goes straight to REPORT with a null result.
                        if (num_samples == '0) begin
                            result_sum     <= '0;
                            result_min     <= '0;
                            result_max     <= '0;
                            result_count   <= '0;
                            result_timeout <= 1'b0;
                        end
                    end
                end
                c_ST_ARM: begin
                    r_sum   <= '0;
                    r_count <= '0;
                    r_gap   <= '0;
                    r_min   <= '1;
                    r_max   <= '0;
                end
                c_ST_COLLECT: begin
                    if (phase_tag_valid) begin
                        r_sum   <= w_sum_nxt;
                        r_count <= w_count_inc;
                        r_min   <= w_min_nxt;
                        r_max   <= w_max_nxt;
                        r_gap   <= '0;
                    end else if (r_gap != c_GAP_MAX) begin
                        r_gap <= r_gap + TIMEOUT_W'(1);
                    end

                    if (w_state_nxt == c_ST_REPORT) begin
                        if (phase_tag_valid) begin
                            result_sum     <= w_sum_nxt;
                            result_min     <= w_min_nxt;
                            result_max     <= w_max_nxt;
                            result_count   <= w_count_inc;
                            result_timeout <= 1'b0;
                        end else begin
                            // Timeout: report the partial burst. With no
                            // samples, min still holds its all-ones seed.
                            result_sum     <= r_sum;
                            result_min     <= (r_count == '0) ? '0 : r_min;
                            result_max     <= (r_count == '0) ? '0 : r_max;
                            result_count   <= r_count;
                            result_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    // REPORT holds everything stable for the handshake.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_measure_ctrl
// Description : Self-checking bench for phase_measure_ctrl. A table of burst
//               vectors is applied in a loop; expected results are queued when
//               each burst is started and compared when the result handshake
//               completes. Hand-written sequences cover back-pressure and
//               mid-burst reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_measure_ctrl;

    localparam int PHASE_COUNT_W = 12;
    localparam int CLK0_COUNT_W  = 4;
    localparam int NSAMP_W       = 8;
    localparam int TIMEOUT_W     = 20;
    localparam int ACC_W         = PHASE_COUNT_W + NSAMP_W;

    logic                                  clk_sample = 1'b0;
    logic                                  rst;
    logic                                  start;
    logic [NSAMP_W-1:0]                    num_samples;
    logic [TIMEOUT_W-1:0]                  timeout_cycles;
    logic                                  busy;
    logic                                  pd_rst;
    logic [PHASE_COUNT_W+CLK0_COUNT_W-1:0] phase_tag;
    logic                                  phase_tag_valid;
    logic                                  result_valid;
    logic                                  result_ready;
    logic [ACC_W-1:0]                      result_sum;
    logic [PHASE_COUNT_W-1:0]              result_min;
    logic [PHASE_COUNT_W-1:0]              result_max;
    logic [NSAMP_W-1:0]                    result_count;
    logic                                  result_timeout;

    always #5 clk_sample = ~clk_sample;

    phase_measure_ctrl #(
        .PHASE_COUNT_W (PHASE_COUNT_W),
        .CLK0_COUNT_W  (CLK0_COUNT_W),
        .NSAMP_W       (NSAMP_W),
        .TIMEOUT_W     (TIMEOUT_W),
        .ACC_W         (ACC_W)
    ) dut (
        .clk_sample      (clk_sample),
        .rst             (rst),
        .start           (start),
        .num_samples     (num_samples),
        .timeout_cycles  (timeout_cycles),
        .busy            (busy),
        .pd_rst          (pd_rst),
        .phase_tag       (phase_tag),
        .phase_tag_valid (phase_tag_valid),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_sum      (result_sum),
        .result_min      (result_min),
        .result_max      (result_max),
        .result_count    (result_count),
        .result_timeout  (result_timeout)
    );

    typedef struct {
        int                    nsamp;
        int                    tmo;
        int                    ntags;
        logic [3:0][11:0]      tags;   // tag i uses tags[i % 4]
        int                    esum;
        int                    emin;
        int                    emax;
        int                    ecount;
        int                    etmo;
        bit                    noise;  // pulse start with other config during tags
    } vec_t;

    typedef struct {
        int sum;
        int min;
        int max;
        int count;
        int tmo;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int nsamp, input int tmo, input int ntags,
                                input logic [11:0] t0, input logic [11:0] t1,
                                input logic [11:0] t2, input logic [11:0] t3,
                                input int esum, input int emin, input int emax,
                                input int ecount, input int etmo, input bit noise);
        vec_t v;
        v.nsamp  = nsamp;
        v.tmo    = tmo;
        v.ntags  = ntags;
        v.tags   = {t3, t2, t1, t0};
        v.esum   = esum;
        v.emin   = emin;
        v.emax   = emax;
        v.ecount = ecount;
        v.etmo   = etmo;
        v.noise  = noise;
        return v;
    endfunction

    // Scoreboard: compare every completed result handshake against the queue.
    always @(negedge clk_sample) begin : monitor
        res_t e;
        #1;
        if (result_valid && result_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("result_sum",     result_sum,     e.sum);
                check("result_min",     result_min,     e.min);
                check("result_max",     result_max,     e.max);
                check("result_count",   result_count,   e.count);
                check("result_timeout", result_timeout, e.tmo);
            end
        end
    end

    // Start a burst, feed its tags back to back, check latency and return to IDLE.
    // Latency is counted in cycles from the cycle carrying the last tag (or the
    // ARM cycle when there are none): 1 when the count completes, T+1 when the
    // gap timeout of T idle cycles ends the burst.
    task automatic run_burst(input vec_t v);
        int lat;
        int exp_lat;
        @(negedge clk_sample);
        start          = 1'b1;
        num_samples    = NSAMP_W'(v.nsamp);
        timeout_cycles = TIMEOUT_W'(v.tmo);
        sb_q.push_back('{v.esum, v.emin, v.emax, v.ecount, v.etmo});
        @(negedge clk_sample);
        start          = 1'b0;
        // Config inputs wander after the start; the latched copy must be used.
        num_samples    = NSAMP_W'($urandom);
        timeout_cycles = TIMEOUT_W'($urandom_range(1, 3));
        if (v.nsamp == 0) begin
            check("empty_result_valid", result_valid, 1);
            check("empty_pd_rst", pd_rst, 1);
        end else begin
            check("arm_pd_rst", pd_rst, 1);
            check("arm_busy", busy, 1);
            // Strobe in ARM must be ignored.
            phase_tag_valid = 1'b1;
            phase_tag       = 16'h0001;
            for (int i = 0; i < v.ntags; i++) begin
                @(negedge clk_sample);
                if (i == 0) check("collect_pd_rst", pd_rst, 0);
                phase_tag_valid = 1'b1;
                phase_tag       = {4'($urandom), v.tags[i % 4]};
                if (v.noise) begin
                    start          = 1'b1;
                    num_samples    = 8'd1;
                    timeout_cycles = 20'd1;
                end
            end
            exp_lat = (v.etmo != 0) ? v.tmo + 1 : 1;
            lat = 0;
            do begin
                @(negedge clk_sample);
                phase_tag_valid = 1'b0;
                start           = 1'b0;
                lat++;
            end while (!result_valid && lat < 400);
            check("result_latency", lat, exp_lat);
        end
        // result_ready is high, so the handshake completes on this edge.
        @(negedge clk_sample);
        check("idle_busy", busy, 0);
        check("idle_result_valid", result_valid, 0);
        check("idle_pd_rst", pd_rst, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs[8];
        vec_t v;

        vecs[0] = mk(4,   0,  4,   12'd10,   12'd12,   12'd8,    12'd14,   44,      8,    14,   4,   0, 1'b1);
        vecs[1] = mk(3,   50, 1,   12'd5,    12'd0,    12'd0,    12'd0,    5,       5,    5,    1,   1, 1'b0);
        vecs[2] = mk(0,   0,  0,   12'd0,    12'd0,    12'd0,    12'd0,    0,       0,    0,    0,   0, 1'b0);
        vecs[3] = mk(2,   0,  2,   12'd4095, 12'd0,    12'd0,    12'd0,    4095,    0,    4095, 2,   0, 1'b0);
        vecs[4] = mk(4,   3,  2,   12'd7,    12'd3,    12'd0,    12'd0,    10,      3,    7,    2,   1, 1'b0);
        vecs[5] = mk(3,   1,  3,   12'd100,  12'd50,   12'd200,  12'd0,    350,     50,   200,  3,   0, 1'b0);
        vecs[6] = mk(2,   1,  0,   12'd0,    12'd0,    12'd0,    12'd0,    0,       0,    0,    0,   1, 1'b0);
        vecs[7] = mk(255, 0,  255, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1044225, 4095, 4095, 255, 0, 1'b0);

        rst             = 1'b1;
        start           = 1'b0;
        num_samples     = '0;
        timeout_cycles  = '0;
        phase_tag       = '0;
        phase_tag_valid = 1'b0;
        result_ready    = 1'b1;
        repeat (3) @(negedge clk_sample);
        check("reset_busy",         busy,           0);
        check("reset_pd_rst",       pd_rst,         1);
        check("reset_result_valid", result_valid,   0);
        check("reset_sum",          result_sum,     0);
        check("reset_min",          result_min,     0);
        check("reset_max",          result_max,     0);
        check("reset_count",        result_count,   0);
        check("reset_timeout",      result_timeout, 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_burst(vecs[k]);
        end

        // Back-pressure: result held stable, start ignored in REPORT and in
        // the handshake cycle itself.
        result_ready = 1'b0;
        @(negedge clk_sample);
        start          = 1'b1;
        num_samples    = 8'd2;
        timeout_cycles = 20'd0;
        sb_q.push_back('{50, 20, 30, 2, 0});
        @(negedge clk_sample);
        start = 1'b0;
        @(negedge clk_sample);
        phase_tag_valid = 1'b1;
        phase_tag       = 16'h0014;
        @(negedge clk_sample);
        phase_tag       = 16'h001E;
        @(negedge clk_sample);
        phase_tag_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", result_valid, 1);
            check("bp_sum",   result_sum,   50);
            check("bp_min",   result_min,   20);
            check("bp_max",   result_max,   30);
            check("bp_count", result_count, 2);
            start       = (c == 3);
            num_samples = 8'd0;
            @(negedge clk_sample);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        num_samples  = 8'd5;
        @(negedge clk_sample);
        start = 1'b0;
        check("bp_idle_busy",  busy,         0);
        check("bp_idle_valid", result_valid, 0);

        // Reset in the middle of COLLECT after two samples: no result, clean restart.
        @(negedge clk_sample);
        start          = 1'b1;
        num_samples    = 8'd4;
        timeout_cycles = 20'd0;
        @(negedge clk_sample);
        start = 1'b0;
        @(negedge clk_sample);
        phase_tag_valid = 1'b1;
        phase_tag       = 16'd100;
        @(negedge clk_sample);
        phase_tag       = 16'd200;
        @(negedge clk_sample);
        phase_tag_valid = 1'b0;
        rst             = 1'b1;
        @(negedge clk_sample);
        check("mid_rst_busy",   busy,         0);
        check("mid_rst_pd_rst", pd_rst,       1);
        check("mid_rst_valid",  result_valid, 0);
        check("mid_rst_sum",    result_sum,   0);
        rst = 1'b0;
        v = mk(2, 0, 2, 12'd7, 12'd9, 12'd0, 12'd0, 16, 7, 9, 2, 0, 1'b0);
        run_burst(v);

        for (int w = 0; w < 20 && sb_q.size() != 0; w++) begin
            @(negedge clk_sample);
        end
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
